// File: rtl/dcnn_rle_pkg.sv
// Shared types and run-word field positions for the RLE row decoder.
package dcnn_rle_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXPAND = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } rle_state_e;

  localparam int RLE_VAL_BIT = 15;
  localparam int RLE_CNT_LSB = 0;
  localparam int RLE_CNT_MSB = 14;

endpackage

// File: rtl/rle_row_buffer.sv
// Row register with write pointer for the RLE row decoder.
// full is high while the pointer sits on the last pixel, i.e. the next write
// completes the row. Optional macro RLE_ROW_STATS_EN adds a ones counter.
module rle_row_buffer #(
  parameter int IMG_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic             wr_val,
  output logic [IMG_W-1:0] row_data,
  output logic             full
`ifdef RLE_ROW_STATS_EN
  ,
  output logic [$clog2(IMG_W+1)-1:0] row_ones
`endif
);

  localparam int PW = $clog2(IMG_W + 1);

  logic [PW-1:0] pix_ptr;

  assign full = (pix_ptr == PW'(IMG_W - 1));

  // pixel write at the pointer; clear only rewinds the pointer since every row is fully rewritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_data <= '0;
      pix_ptr  <= '0;
    end else if (clr) begin
      pix_ptr  <= '0;
    end else if (wr) begin
      row_data[pix_ptr] <= wr_val;
      pix_ptr           <= pix_ptr + PW'(1);
    end
  end

`ifdef RLE_ROW_STATS_EN
  // count of 1-pixels written into the current row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_ones <= '0;
    end else if (clr) begin
      row_ones <= '0;
    end else if (wr && wr_val) begin
      row_ones <= row_ones + PW'(1);
    end
  end
`endif

endmodule

// File: rtl/rle_row_decoder.sv
// Run-length expander: 16-bit run words in, IMG_W-pixel rows out, one pixel per clock.
// Optional macro RLE_ROW_STATS_EN adds the row_ones output.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | in_ready high, waiting for a run word
// EXPAND | writing one pixel of the current run per cycle
// EMIT   | row_valid high, holding the row until row_ready
// DONE   | one-cycle done pulse, overrun capture
module rle_row_decoder
  import dcnn_rle_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CNT_W = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(IMG_H+1)-1:0] num_rows,
  input  logic                       in_valid,
  input  logic [15:0]                in_word,
  output logic                       in_ready,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [IMG_W-1:0]           row_data,
  output logic [$clog2(IMG_H)-1:0]   row_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       err_overrun
`ifdef RLE_ROW_STATS_EN
  ,
  output logic [$clog2(IMG_W+1)-1:0] row_ones
`endif
);

  localparam int RW = $clog2(IMG_H + 1);
  localparam int IW = $clog2(IMG_H);

  rle_state_e       state_q, state_d;
  logic [RW-1:0]    rows_left_q;
  logic [CNT_W-1:0] run_left_q;
  logic             value_q;
  logic [IW-1:0]    row_idx_q;
  logic             err_q;
  logic             load, take, wr, ack, fin;
  logic             row_full;

  rle_row_buffer #(.IMG_W(IMG_W)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load | ack),
    .wr       (wr),
    .wr_val   (value_q),
    .row_data (row_data),
    .full     (row_full)
`ifdef RLE_ROW_STATS_EN
    ,
    .row_ones (row_ones)
`endif
  );

  assign row_idx     = row_idx_q;
  assign err_overrun = err_q;
  assign busy        = (state_q != IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state, handshake outputs and datapath strobes
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    row_valid = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    take      = 1'b0;
    wr        = 1'b0;
    ack       = 1'b0;
    fin       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          take = 1'b1;
          if (in_word[RLE_CNT_MSB:RLE_CNT_LSB] != '0) state_d = EXPAND;
        end
      end
      EXPAND: begin
        wr = 1'b1;
        if (row_full)                        state_d = EMIT;
        else if (run_left_q == CNT_W'(1))    state_d = FETCH;
      end
      EMIT: begin
        row_valid = 1'b1;
        if (row_ready) begin
          ack = 1'b1;
          if (rows_left_q == RW'(1))         state_d = DONE;
          else if (run_left_q != '0)         state_d = EXPAND;
          else                               state_d = FETCH;
        end
      end
      DONE: begin
        done    = 1'b1;
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // run and row counters, overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_left_q <= '0;
      run_left_q  <= '0;
      value_q     <= 1'b0;
      row_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      if (load) begin
        rows_left_q <= (num_rows == '0) ? RW'(IMG_H) : num_rows;
        row_idx_q   <= '0;
        err_q       <= 1'b0;
      end
      if (take) begin
        value_q    <= in_word[RLE_VAL_BIT];
        run_left_q <= in_word[RLE_CNT_MSB:RLE_CNT_LSB];
      end
      if (wr) run_left_q <= run_left_q - CNT_W'(1);
      if (ack) begin
        row_idx_q   <= row_idx_q + IW'(1);
        rows_left_q <= rows_left_q - RW'(1);
      end
      if (fin) begin
        err_q      <= (run_left_q != '0);
        run_left_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rle_row_decoder.sv
// Self-checking bench for rle_row_decoder: directed cases plus randomized images
// checked against a run-arithmetic reference model.
module tb_rle_row_decoder;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int NRW   = $clog2(IMG_H + 1);
  localparam int IW    = $clog2(IMG_H);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [NRW-1:0]   num_rows;
  logic             in_valid;
  logic [15:0]      in_word;
  logic             in_ready;
  logic             row_valid;
  logic             row_ready;
  logic [IMG_W-1:0] row_data;
  logic [IW-1:0]    row_idx;
  logic             busy;
  logic             done;
  logic             err_overrun;
`ifdef RLE_ROW_STATS_EN
  logic [$clog2(IMG_W+1)-1:0] row_ones;
`endif

  int passed = 0;
  int total  = 0;

  logic [15:0]      words[$];
  logic [IMG_W-1:0] exp_rows[$];
  bit               exp_ovr;

  always #5 clk = ~clk;

  rle_row_decoder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_rows    (num_rows),
    .in_valid    (in_valid),
    .in_word     (in_word),
    .in_ready    (in_ready),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .busy        (busy),
    .done        (done),
    .err_overrun (err_overrun)
`ifdef RLE_ROW_STATS_EN
    ,
    .row_ones    (row_ones)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected rows from the run list: each run fills min(remaining, space in row) pixels at once.
  task automatic build_model(input int n_eff);
    logic [63:0] cur, mask;
    int pos, rows, rem, take;
    bit v;
    cur = '0; pos = 0; rows = 0;
    exp_rows.delete();
    exp_ovr = 1'b0;
    for (int i = 0; i < words.size(); i++) begin
      rem = int'(words[i][14:0]);
      v   = words[i][15];
      while (rem > 0 && rows < n_eff) begin
        take = (rem < IMG_W - pos) ? rem : IMG_W - pos;
        mask = ((64'd1 << take) - 64'd1) << pos;
        cur  = v ? (cur | mask) : (cur & ~mask);
        pos += take;
        rem -= take;
        if (pos == IMG_W) begin
          exp_rows.push_back(cur[IMG_W-1:0]);
          pos = 0;
          rows++;
        end
      end
      if (rows == n_eff) begin
        exp_ovr = (rem > 0);
        break;
      end
    end
  endtask

  task automatic gen_words(input int n_eff);
    int tot, r;
    words.delete();
    tot = 0;
    while (tot < n_eff * IMG_W) begin
      case ($urandom_range(9))
        0:       r = 0;
        1:       r = $urandom_range(70, 29);
        default: r = $urandom_range(12, 1);
      endcase
      words.push_back({1'($urandom_range(1)), 15'(r)});
      tot += r;
    end
  endtask

  // Decodes one image from words[], optionally pulsing a stray start during EXPAND.
  task automatic run_image(input string nm, input int nrows, input int rr_pct, input bit poke);
    int n_eff, wi, ri;
    bit got_done, poked;
    n_eff = (nrows == 0) ? IMG_H : nrows;
    wi = 0; ri = 0; got_done = 0; poked = 0;
    build_model(n_eff);
    @(negedge clk);
    start = 1'b1;
    num_rows = NRW'(nrows);
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy"}, busy, 1);
    check({nm, "_err_clr"}, err_overrun, 0);
    for (int cyc = 0; cyc < 8000 && !got_done; cyc++) begin
      if (done) got_done = 1;
      in_valid  = (wi < words.size()) && ($urandom_range(99) < 85);
      in_word   = (wi < words.size()) ? words[wi] : 16'h0;
      row_ready = ($urandom_range(99) < rr_pct);
      if (poke && !poked && busy && !in_ready && !row_valid && !done) begin
        start = 1'b1;
        num_rows = NRW'(5);
        poked = 1;
      end else begin
        start = 1'b0;
      end
      if (row_valid && row_ready) begin
        if (ri < exp_rows.size()) check({nm, "_row_data"}, row_data, exp_rows[ri]);
        else                      check({nm, "_extra_row"}, 1, 0);
        check({nm, "_row_idx"}, row_idx, ri);
`ifdef RLE_ROW_STATS_EN
        if (ri < exp_rows.size()) check({nm, "_row_ones"}, row_ones, $countones(exp_rows[ri]));
`endif
        ri++;
      end
      if (in_valid && in_ready) wi++;
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    row_ready = 1'b0;
    check({nm, "_done_seen"}, got_done, 1);
    check({nm, "_row_count"}, ri, n_eff);
    check({nm, "_err_overrun"}, err_overrun, exp_ovr);
    check({nm, "_idle_busy"}, busy, 0);
    check({nm, "_done_once"}, done, 0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_in_ready"}, in_ready, 0);
    check({nm, "_row_valid"}, row_valid, 0);
    check({nm, "_row_data"}, row_data, 0);
    check({nm, "_row_idx"}, row_idx, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_done"}, done, 0);
    check({nm, "_err"}, err_overrun, 0);
  endtask

  initial begin
    int k, nr;
    rst_n = 1'b0; start = 1'b0; num_rows = '0;
    in_valid = 1'b0; in_word = '0; row_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    words = '{16'h801C};
    run_image("full_run", 1, 100, 0);
    check("full_run_value", exp_rows[0], 28'hFFFFFFF);

    words = '{16'h000A, 16'h8012};
    run_image("two_runs", 1, 100, 0);
    check("two_runs_value", exp_rows[0], 28'hFFFFC00);

    words = '{16'h000A, 16'h0000, 16'h8012};
    run_image("zero_word", 1, 100, 0);

    words = '{16'h801E, 16'h001A};
    run_image("span", 2, 100, 0);

    // backpressure in EMIT
    @(negedge clk);
    start = 1'b1; num_rows = NRW'(1);
    @(negedge clk);
    start = 1'b0;
    check("bp_in_ready", in_ready, 1);
    in_valid = 1'b1; in_word = 16'h801C;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!row_valid && k < 100) begin @(negedge clk); k++; end
    check("bp_row_valid_reached", row_valid, 1);
    for (int c = 0; c < 5; c++) begin
      row_ready = 1'b0;
      check("bp_hold_valid", row_valid, 1);
      check("bp_hold_data", row_data, 28'hFFFFFFF);
      check("bp_hold_idx", row_idx, 0);
      check("bp_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    row_ready = 1'b1;
    @(negedge clk);
    row_ready = 1'b0;
    check("bp_accepted", row_valid, 0);
    check("bp_done", done, 1);
    @(negedge clk);
    check("bp_done_pulse", done, 0);
    check("bp_err", err_overrun, 0);

    words = '{16'h8028};
    run_image("overrun", 1, 100, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("overrun_sticky", err_overrun, 1);
    end

    // reset during EXPAND
    @(negedge clk);
    start = 1'b1; num_rows = NRW'(3);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_word = 16'h8010;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_mid_reset");
    words = '{16'h801C};
    run_image("post_reset_run", 1, 100, 0);

    words = '{16'h000A, 16'h8012, 16'h8005, 16'h0017};
    run_image("ignored_start", 2, 100, 1);

    for (int t = 0; t < 16; t++) begin
      nr = (t == 0) ? 0 : $urandom_range(IMG_H, 1);
      gen_words((nr == 0) ? IMG_H : nr);
      run_image("rand", nr, $urandom_range(100, 30), t[0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rle_row_decoder.md
Name: rle_row_decoder

Overview:
- Run-length expander on the compressed-image path; sits directly downstream of the cpu's 16-bit data output.
- Consumes 16-bit run words and rebuilds binary image rows IMG_W pixels wide, IMG_H rows per image.
- Hands each completed row to the chip's row-consuming logic over a valid/ready handshake.
- One pixel is expanded per clock.

Parameters:
- IMG_W, 28, pixels per row (row_data width)
- IMG_H, 28, maximum rows per image
- CNT_W, 15, run-length field width; word is CNT_W+1 bits

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins an image decode, accepted only in IDLE
- num_rows  in  $clog2(IMG_H+1)  rows to produce; sampled with start; 0 is treated as IMG_H
- in_valid  in  1  run word valid
- in_word  in  16  [15] = pixel value, [14:0] = run length
- in_ready  out  1  decoder accepts in_word this cycle
- row_valid  out  1  row_data holds a completed row
- row_ready  in  1  downstream accepts the row
- row_data  out  IMG_W  pixel 0 at bit 0
- row_idx  out  $clog2(IMG_H)  index of the row on row_data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at image completion
- err_overrun  out  1  sticky until next start; pixels remained when the last row completed

Behaviour:
- Reset values: every output is 0; state is IDLE; all internal registers are 0.
- State machine: IDLE -> FETCH -> EXPAND -> EMIT -> FETCH or EXPAND, and EMIT -> DONE -> IDLE.
- IDLE: start loads rows_left = num_rows (0 is replaced by IMG_H), clears pix_ptr, row_idx and err_overrun, then moves to FETCH.
  - start in any other state is ignored.
- FETCH: in_ready = 1 only in this state.
  - On in_valid & in_ready, latch value = in_word[15] and run_left = in_word[14:0].
  - If run_left is 0, the word is consumed with no effect and the decoder stays in FETCH.
  - Otherwise go to EXPAND on the next cycle.
- EXPAND: each cycle writes row_data[pix_ptr] = value, increments pix_ptr and decrements run_left.
  - When pix_ptr reaches IMG_W-1 on a write, go to EMIT.
  - Otherwise, when run_left reaches 0, return to FETCH.
- Row-end and run-end in the same cycle: EMIT takes priority. After the handshake the decoder goes to FETCH because run_left is 0.
- EMIT: row_valid = 1. row_data and row_idx stay stable until row_valid & row_ready.
  - On that handshake: row_idx increments, pix_ptr clears, rows_left decrements.
  - rows_left reaching 0 goes to DONE.
  - Otherwise go to EXPAND if run_left > 0 (the run spans rows), else FETCH.
- DONE: done = 1 for one cycle.
  - err_overrun is set if run_left > 0 at this point.
  - The leftover run is discarded and the decoder returns to IDLE.
- Unused row bits: none. Every row is fully written before EMIT.
- Latency:
  - word acceptance to first pixel write: 1 cycle;
  - last pixel write to row_valid: 1 cycle;
  - one row takes at least IMG_W + (number of words) cycles.
- Reset mid-operation returns the decoder to IDLE immediately. Partial row data is lost and every output goes to its reset value.
- Stalls: in_valid low in FETCH, or row_ready low in EMIT, stalls indefinitely; no timeout.

Optional Feature:
- Macro: RLE_ROW_STATS_EN.
- With it defined:
  - adds output row_ones, width $clog2(IMG_W+1), giving the count of 1-pixels in row_data;
  - the count accumulates during EXPAND and is valid with row_valid;
  - it clears after each row handshake.
- Without it, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package dcnn_rle_pkg holds:
  - the state enum (IDLE, FETCH, EXPAND, EMIT, DONE);
  - the word field constants: RLE_VAL_BIT = 15, RLE_CNT_LSB = 0, RLE_CNT_MSB = 14.
- One sub-module, rle_row_buffer: the IMG_W-bit row register plus pix_ptr, with write-at-pointer, clear and full flag (plus the ones counter when RLE_ROW_STATS_EN is defined).
- The FSM and run/row counters stay in rle_row_decoder.

Test Plan:
- Single full run: num_rows = 1, word 0x801C (value 1, run 28) -> row_data = 0xFFFFFFF, row_idx = 0, done pulse, err_overrun = 0.
- Two runs: num_rows = 1, words 0x000A then 0x8012 -> row_data = 0xFFFFC00; a 0x0000 word inserted between them -> consumed, same result.
- Run spanning rows: num_rows = 2, words 0x801E (1×30) then 0x001A (0×26) -> row0 = 0xFFFFFFF, row1 = 0x0000003, row_idx 0 then 1.
- Backpressure: hold row_ready = 0 for 5 cycles during EMIT -> row_valid stays 1, row_data and row_idx stable, in_ready = 0; the row is accepted on the cycle row_ready rises.
- Overrun: num_rows = 1, word 0x8028 (1×40) -> row_data = 0xFFFFFFF, done pulse, err_overrun = 1, held until next start.
- Reset mid-EXPAND: drop rst_n for 1 cycle -> all outputs 0 and state IDLE; a following start with 0x801C decodes correctly.
- Ignored start: start pulsed during EXPAND -> current image continues unchanged.
